// File: rtl/branch_predictor_if.sv
// Bundle between the fetch/execute stages and the branch predictor.
// There is no backpressure on any path: fetch_valid and upd_valid are
// single-cycle qualifiers sampled on the rising clock edge. The predictor
// always accepts them and never stalls its producers. pred_branch and
// pred_branch_addr are combinational and valid in the same cycle as
// fetch_addr.
interface branch_predictor_if #(
  parameter int word_width = 32
);
  logic [word_width-1:0] fetch_addr;
  logic                  fetch_valid;
  logic                  stall;
  logic                  redirect;
  logic                  clear;
  logic                  upd_valid;
  logic [word_width-1:0] upd_addr;
  logic                  upd_taken;
  logic [word_width-1:0] upd_target;
  logic                  pred_branch;
  logic [word_width-1:0] pred_branch_addr;

  // Pipeline side: drives fetch/update, consumes the prediction.
  modport master (
    output fetch_addr, fetch_valid, stall, redirect, clear,
           upd_valid, upd_addr, upd_taken, upd_target,
    input  pred_branch, pred_branch_addr
  );

  // Predictor side.
  modport slave (
    input  fetch_addr, fetch_valid, stall, redirect, clear,
           upd_valid, upd_addr, upd_taken, upd_target,
    output pred_branch, pred_branch_addr
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction
// counters. Lookup is combinational from registered state. Training from
// the execute stage lands on the next clock edge, with no bypass.
module branch_predictor #(
  parameter int word_width = 32,
  parameter int entries    = 16
) (
  input  logic                clk,
  input  logic                reset,
  branch_predictor_if.slave   bp
);
  localparam int idx_bits = $clog2(entries);
  localparam int tag_bits = word_width - idx_bits - 2;

  logic                  valid_q  [entries];
  logic [tag_bits-1:0]   tag_q    [entries];
  logic [word_width-1:0] target_q [entries];
  logic [1:0]            ctr_q    [entries];

  logic [idx_bits-1:0] fetch_idx;
  logic [tag_bits-1:0] fetch_tag;
  logic                fetch_hit;
  logic [idx_bits-1:0] upd_idx;
  logic [tag_bits-1:0] upd_tag;
  logic                upd_hit;

  logic                  upd_we;
  logic                  valid_d;
  logic [tag_bits-1:0]   tag_d;
  logic [word_width-1:0] target_d;
  logic [1:0]            ctr_d;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_low_bits;
  assign unused_low_bits = ^{bp.fetch_addr[1:0], bp.upd_addr[1:0]};

  assign fetch_idx = bp.fetch_addr[idx_bits+1:2];
  assign fetch_tag = bp.fetch_addr[word_width-1:idx_bits+2];
  assign upd_idx   = bp.upd_addr[idx_bits+1:2];
  assign upd_tag   = bp.upd_addr[word_width-1:idx_bits+2];
  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Lookup: the PC gives pred_branch priority over stall/redirect, so
  // both must gate the prediction here.
  always_comb begin
    bp.pred_branch      = bp.fetch_valid & ~bp.stall & ~bp.redirect &
                          fetch_hit & ctr_q[fetch_idx][1];
    bp.pred_branch_addr = bp.pred_branch ? target_q[fetch_idx] : '0;
  end

  // Next contents of the single entry selected by upd_addr.
  always_comb begin
    upd_we   = 1'b0;
    valid_d  = valid_q[upd_idx];
    tag_d    = tag_q[upd_idx];
    target_d = target_q[upd_idx];
    ctr_d    = ctr_q[upd_idx];
    if (bp.upd_valid) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (bp.upd_taken) begin
          ctr_d    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
          target_d = bp.upd_target;
        end else begin
          ctr_d    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
        end
      end else if (bp.upd_taken) begin
        // Miss taken: allocate, overwriting whatever alias lived here.
        upd_we   = 1'b1;
        valid_d  = 1'b1;
        tag_d    = upd_tag;
        target_d = bp.upd_target;
        ctr_d    = 2'b10;
      end
    end
  end

  // Table state: async reset wipes training; clear drops only valid bits
  // and wins over a same-cycle update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bp.clear) begin
      for (int i = 0; i < entries; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_we) begin
      valid_q[upd_idx]  <= valid_d;
      tag_q[upd_idx]    <= tag_d;
      target_q[upd_idx] <= target_d;
      ctr_q[upd_idx]    <= ctr_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (32-bit words, 16 entries).
module tb_branch_predictor;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  branch_predictor_if #(.word_width(32)) bp_if ();

  branch_predictor #(.word_width(32), .entries(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_if)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Settle combinational lookup, then compare both outputs.
  task automatic check_pred(input string tag, input logic exp_p, input logic [31:0] exp_a);
    #1;
    check({tag, ".pred"}, {31'b0, bp_if.pred_branch}, {31'b0, exp_p});
    check({tag, ".addr"}, bp_if.pred_branch_addr, exp_a);
  endtask

  task automatic fetch(input logic [31:0] a);
    bp_if.fetch_addr  = a;
    bp_if.fetch_valid = 1'b1;
  endtask

  // Present an update for one edge, then drop upd_valid.
  task automatic update(input logic [31:0] a, input logic taken, input logic [31:0] tgt);
    bp_if.upd_valid  = 1'b1;
    bp_if.upd_addr   = a;
    bp_if.upd_taken  = taken;
    bp_if.upd_target = tgt;
    tick();
    bp_if.upd_valid  = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bp_if.fetch_addr  = '0;
    bp_if.fetch_valid = 1'b1;
    bp_if.stall       = 1'b0;
    bp_if.redirect    = 1'b0;
    bp_if.clear       = 1'b0;
    bp_if.upd_valid   = 1'b0;
    bp_if.upd_addr    = '0;
    bp_if.upd_taken   = 1'b0;
    bp_if.upd_target  = '0;

    // 1. Held in reset: sweep fetch addresses, no prediction anywhere.
    for (int i = 0; i < 16; i++) begin
      fetch(32'(i * 4));
      check_pred($sformatf("reset_sweep_%0d", i), 1'b0, 32'h0);
      tick();
    end
    #2 reset = 1'b1;
    tick();
    fetch(32'h40);
    check_pred("post_reset_40", 1'b0, 32'h0);

    // 2. Allocate: no same-cycle bypass, visible next cycle, low bits ignored.
    bp_if.upd_valid  = 1'b1;
    bp_if.upd_addr   = 32'h40;
    bp_if.upd_taken  = 1'b1;
    bp_if.upd_target = 32'h100;
    fetch(32'h40);
    check_pred("alloc_same_cycle", 1'b0, 32'h0);
    tick();
    bp_if.upd_valid = 1'b0;
    check_pred("alloc_next", 1'b1, 32'h100);
    fetch(32'h42);
    check_pred("alloc_lowbits", 1'b1, 32'h100);
    fetch(32'h40);

    // 3. Counter training: 10 -> 01 -> 10 -> 11 (saturate) -> 10.
    update(32'h40, 1'b0, 32'h0);
    check_pred("train_nt_01", 1'b0, 32'h0);
    update(32'h40, 1'b1, 32'h200);
    check_pred("train_t_10", 1'b1, 32'h200);
    for (int i = 0; i < 3; i++) begin
      update(32'h40, 1'b1, 32'h200);
      check_pred($sformatf("train_sat_%0d", i), 1'b1, 32'h200);
    end
    update(32'h40, 1'b0, 32'h0);
    check_pred("train_nt_from_11", 1'b1, 32'h200);

    // 4. Aliasing: 0x440 shares index 0 with 0x40, different tag.
    fetch(32'h440);
    check_pred("alias_miss", 1'b0, 32'h0);
    update(32'h440, 1'b0, 32'h0);
    fetch(32'h40);
    check_pred("alias_nt_noalloc", 1'b1, 32'h200);
    update(32'h440, 1'b1, 32'h80);
    fetch(32'h440);
    check_pred("alias_alloc", 1'b1, 32'h80);
    fetch(32'h40);
    check_pred("alias_evicted", 1'b0, 32'h0);

    // 5. Suppression with 0x40 trained taken again.
    update(32'h40, 1'b1, 32'h100);
    check_pred("supp_base", 1'b1, 32'h100);
    bp_if.stall = 1'b1;
    check_pred("supp_stall", 1'b0, 32'h0);
    bp_if.stall    = 1'b0;
    bp_if.redirect = 1'b1;
    check_pred("supp_redirect", 1'b0, 32'h0);
    bp_if.redirect    = 1'b0;
    bp_if.fetch_valid = 1'b0;
    check_pred("supp_fetch_valid", 1'b0, 32'h0);
    bp_if.fetch_valid = 1'b1;

    // Update at another index while looking up 0x40: independent.
    bp_if.upd_valid  = 1'b1;
    bp_if.upd_addr   = 32'h44;
    bp_if.upd_taken  = 1'b1;
    bp_if.upd_target = 32'h300;
    check_pred("indep_lookup", 1'b1, 32'h100);
    tick();
    bp_if.upd_valid = 1'b0;
    fetch(32'h44);
    check_pred("indep_alloc", 1'b1, 32'h300);

    // 6. Clear wins over a simultaneous taken update.
    bp_if.clear      = 1'b1;
    bp_if.upd_valid  = 1'b1;
    bp_if.upd_addr   = 32'h80;
    bp_if.upd_taken  = 1'b1;
    bp_if.upd_target = 32'h500;
    tick();
    bp_if.clear     = 1'b0;
    bp_if.upd_valid = 1'b0;
    fetch(32'h40);
    check_pred("clear_40", 1'b0, 32'h0);
    fetch(32'h80);
    check_pred("clear_80", 1'b0, 32'h0);
    fetch(32'h44);
    check_pred("clear_44", 1'b0, 32'h0);

    // Retrain after clear, then async reset mid-cycle.
    update(32'h40, 1'b1, 32'h600);
    fetch(32'h40);
    check_pred("retrain", 1'b1, 32'h600);
    #2 reset = 1'b0;
    check_pred("async_reset_midcycle", 1'b0, 32'h0);
    tick();
    check_pred("async_reset_held", 1'b0, 32'h0);
    #2 reset = 1'b1;
    tick();
    check_pred("after_reset_discarded", 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
